// File: rtl/pc_stack_unit_pkg.sv
// pc_stack_unit_pkg: shared types and constants for the PC / return-stack stage.
// Holds the FSM state enum, the decoder flow encodings, the ALU op codes and default sizes.
package pc_stack_unit_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  // {Jump, Stack_Enable, Stack_Write} encodings from the decoder
  localparam logic [2:0] FLOW_JAL = 3'b111;
  localparam logic [2:0] FLOW_RET = 3'b010;
  localparam logic [2:0] FLOW_JR  = 3'b100;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SEQ = 3'd6,
    ALU_SNE = 3'd7
  } alu_op_e;

endpackage

// File: rtl/pc_stack_unit_return_stack.sv
// return_stack: parameterised LIFO of return addresses, combinational top read.
// Ports: clk_i, rst_ni (sync, active-low), push_i, pop_i, din_i -> top_o, count_o, full_o, empty_o.
module return_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [AW-1:0]            din_i,
  output logic [AW-1:0]            top_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW-1:0] wr_idx, rd_idx;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // illegal push/pop are dropped here; the parent flags the fault
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_idx = cnt_q[PW-1:0];
  assign rd_idx = wr_idx - PW'(1);
  assign top_o  = mem_q[rd_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push)
      cnt_d = cnt_q + (PW+1)'(1);
    else if (do_pop)
      cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // storage is never cleared; entries above count are unreachable
  always_ff @(posedge clk_i) begin
    if (do_push)
      mem_q[wr_idx] <= din_i;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: PC register, next-PC priority mux, return stack and RUN/HALTED/FAULT FSM.
// In: Clock, Reset, Stall, decoder flow bits, Branch_Taken, targets. Out: PC, Halted, flags, Stack_Count.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int STACK_DEPTH = DEPTH_DEF
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Stall,
  input  logic                          Jump,
  input  logic                          Branch,
  input  logic                          Branch_Taken,
  input  logic                          Stack_Enable,
  input  logic                          Stack_Write,
  input  logic                          Halt,
  input  logic [ADDR_WIDTH-1:0]         Jump_Target,
  input  logic [ADDR_WIDTH-1:0]         Branch_Target,
  output logic [ADDR_WIDTH-1:0]         PC,
  output logic                          Halted,
  output logic                          Stack_Overflow,
  output logic                          Stack_Underflow,
  output logic [$clog2(STACK_DEPTH):0]  Stack_Count
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc, stk_top;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  push, pop, stk_full, stk_empty;
  logic [2:0]            flow;
  logic                  is_jal, is_ret, is_jr;

  assign flow   = {Jump, Stack_Enable, Stack_Write};
  assign is_jal = (flow == FLOW_JAL);
  // Jump with a pop encoding is illegal and decodes as RET
  assign is_ret = (flow[1:0] == FLOW_RET[1:0]);
  assign is_jr  = (flow[2:1] == FLOW_JR[2:1]);
  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  return_stack #(
    .AW    (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .top_o   (stk_top),
    .count_o (Stack_Count),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (state_q == ST_RUN && !Stall) begin
      if (Halt) begin
        state_d = ST_HALTED;
      end else if (is_jal) begin
        if (stk_full) begin
          ovf_d   = 1'b1;
          state_d = ST_FAULT;
        end else begin
          push = 1'b1;
          pc_d = Jump_Target;
        end
      end else if (is_ret) begin
        if (stk_empty) begin
          udf_d   = 1'b1;
          state_d = ST_FAULT;
        end else begin
          pop  = 1'b1;
          pc_d = stk_top;
        end
      end else if (is_jr) begin
        pc_d = Jump_Target;
      end else if (Branch && Branch_Taken) begin
        pc_d = Branch_Target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign PC              = pc_q;
  assign Halted          = (state_q != ST_RUN);
  assign Stack_Overflow  = ovf_q;
  assign Stack_Underflow = udf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: scoreboard bench for pc_stack_unit.
// A behavioural model queues expected outputs per cycle; each test pops and compares.
module tb_pc_stack_unit;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Stall = 1'b0;
  logic       Jump = 1'b0;
  logic       Branch = 1'b0;
  logic       Branch_Taken = 1'b0;
  logic       Stack_Enable = 1'b0;
  logic       Stack_Write = 1'b0;
  logic       Halt = 1'b0;
  logic [9:0] Jump_Target = '0;
  logic [9:0] Branch_Target = '0;
  logic [9:0] PC;
  logic       Halted;
  logic       Stack_Overflow;
  logic       Stack_Underflow;
  logic [4:0] Stack_Count;

  pc_stack_unit #(
    .ADDR_WIDTH  (10),
    .STACK_DEPTH (16)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Stall           (Stall),
    .Jump            (Jump),
    .Branch          (Branch),
    .Branch_Taken    (Branch_Taken),
    .Stack_Enable    (Stack_Enable),
    .Stack_Write     (Stack_Write),
    .Halt            (Halt),
    .Jump_Target     (Jump_Target),
    .Branch_Target   (Branch_Target),
    .PC              (PC),
    .Halted          (Halted),
    .Stack_Overflow  (Stack_Overflow),
    .Stack_Underflow (Stack_Underflow),
    .Stack_Count     (Stack_Count)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       rst_n;
    logic       stall;
    logic       jump;
    logic       br;
    logic       taken;
    logic       se;
    logic       sw;
    logic       halt;
    logic [9:0] jt;
    logic [9:0] btg;
  } stim_t;

  typedef struct packed {
    logic [9:0] pc;
    logic [4:0] cnt;
    logic       hlt;
    logic       ovf;
    logic       udf;
  } exp_t;

  logic [9:0] m_pc;
  logic [9:0] m_stk[$];
  logic       m_hlt, m_ovf, m_udf;
  exp_t       sb[$];
  int         n_run = 0;
  int         n_fail = 0;

  function automatic stim_t s_idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_rst();
    stim_t s;
    s = s_idle();
    s.rst_n = 1'b0;
    return s;
  endfunction

  function automatic stim_t s_jal(input logic [9:0] t);
    stim_t s;
    s = s_idle();
    s.jump = 1'b1; s.se = 1'b1; s.sw = 1'b1; s.jt = t;
    return s;
  endfunction

  function automatic stim_t s_ret();
    stim_t s;
    s = s_idle();
    s.se = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_jr(input logic [9:0] t);
    stim_t s;
    s = s_idle();
    s.jump = 1'b1; s.jt = t;
    return s;
  endfunction

  function automatic stim_t s_br(input logic tk, input logic [9:0] t);
    stim_t s;
    s = s_idle();
    s.br = 1'b1; s.taken = tk; s.btg = t;
    return s;
  endfunction

  function automatic stim_t s_halt();
    stim_t s;
    s = s_idle();
    s.halt = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_stall(input stim_t x);
    stim_t s;
    s = x;
    s.stall = 1'b1;
    return s;
  endfunction

  function automatic exp_t obs();
    return {PC, Stack_Count, Halted, Stack_Overflow, Stack_Underflow};
  endfunction

  function automatic string fmt(input exp_t x);
    return $sformatf("pc=%h cnt=%0d halted=%b ovf=%b udf=%b",
                     x.pc, x.cnt, x.hlt, x.ovf, x.udf);
  endfunction

  // drive one cycle, advance the model, queue its expectation
  task automatic apply(input stim_t s);
    exp_t e;
    Reset = s.rst_n; Stall = s.stall; Jump = s.jump;
    Branch = s.br; Branch_Taken = s.taken;
    Stack_Enable = s.se; Stack_Write = s.sw; Halt = s.halt;
    Jump_Target = s.jt; Branch_Target = s.btg;
    if (!s.rst_n) begin
      m_pc = '0; m_stk.delete();
      m_hlt = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (!m_hlt && !s.stall) begin
      if (s.halt) begin
        m_hlt = 1'b1;
      end else if (s.jump && s.se && s.sw) begin
        if (m_stk.size() == 16) begin
          m_ovf = 1'b1; m_hlt = 1'b1;
        end else begin
          m_stk.push_back(m_pc + 10'd1);
          m_pc = s.jt;
        end
      end else if (s.se && !s.sw) begin
        if (m_stk.size() == 0) begin
          m_udf = 1'b1; m_hlt = 1'b1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (s.jump) begin
        m_pc = s.jt;
      end else if (s.br && s.taken) begin
        m_pc = s.btg;
      end else begin
        m_pc = m_pc + 10'd1;
      end
    end
    e.pc = m_pc; e.cnt = 5'(m_stk.size());
    e.hlt = m_hlt; e.ovf = m_ovf; e.udf = m_udf;
    sb.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    stim_t q[$];
    exp_t  e, o;
    q.push_back(s_rst());
    repeat (5) q.push_back(s_idle());
    q.push_back(s_rst());
    foreach (q[i]) begin
      apply(q[i]);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got %s, want %s", i, fmt(o), fmt(e));
      end
      if (i == 5) begin
        n_run++;
        if (PC !== 10'd5) begin
          n_fail++;
          $display("FAIL reset_pc5: got %h, want 005", PC);
        end
      end
    end
  endtask

  task automatic test_wrap();
    stim_t q[$];
    exp_t  e, o;
    q.push_back(s_rst());
    q.push_back(s_jr(10'h3FF));
    q.push_back(s_idle());
    q.push_back(s_jr(10'h3FF));
    q.push_back(s_jal(10'h155));
    q.push_back(s_ret());
    foreach (q[i]) begin
      apply(q[i]);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap step %0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_jal_ret();
    stim_t q[$];
    exp_t  e, o;
    q.push_back(s_rst());
    q.push_back(s_jr(10'h007));
    q.push_back(s_jal(10'h040));
    q.push_back(s_ret());
    foreach (q[i]) begin
      apply(q[i]);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL jal_ret step %0d: got %s, want %s", i, fmt(o), fmt(e));
      end
      if (i == 3) begin
        n_run++;
        if (PC !== 10'h008 || Stack_Count !== 5'd0) begin
          n_fail++;
          $display("FAIL ret_to_8: got pc=%h cnt=%0d, want pc=008 cnt=0",
                   PC, Stack_Count);
        end
      end
    end
  endtask

  task automatic test_overflow();
    stim_t q[$];
    exp_t  e, o;
    q.push_back(s_rst());
    for (int k = 0; k < 16; k++)
      q.push_back(s_jal(10'h100 + 10'(k * 3)));
    q.push_back(s_jal(10'h3E0));
    q.push_back(s_ret());
    q.push_back(s_idle());
    q.push_back(s_rst());
    q.push_back(s_idle());
    foreach (q[i]) begin
      apply(q[i]);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL overflow step %0d: got %s, want %s", i, fmt(o), fmt(e));
      end
      if (i == 18) begin
        n_run++;
        if (Stack_Overflow !== 1'b1 || Halted !== 1'b1 ||
            Stack_Count !== 5'd16 || PC !== 10'h12D) begin
          n_fail++;
          $display("FAIL overflow_frozen: got %s, want pc=12d cnt=16 halted=1 ovf=1",
                   fmt(o));
        end
      end
    end
  endtask

  task automatic test_branch_halt();
    stim_t q[$];
    exp_t  e, o;
    q.push_back(s_rst());
    q.push_back(s_idle());
    q.push_back(s_idle());
    q.push_back(s_br(1'b0, 10'h2AA));
    q.push_back(s_br(1'b1, 10'h020));
    q.push_back(s_stall(s_halt()));
    q.push_back(s_stall(s_jr(10'h111)));
    q.push_back(s_halt());
    q.push_back(s_idle());
    q.push_back(s_jr(10'h005));
    q.push_back(s_rst());
    foreach (q[i]) begin
      apply(q[i]);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL branch_halt step %0d: got %s, want %s", i, fmt(o), fmt(e));
      end
      if (i == 7) begin
        n_run++;
        if (Halted !== 1'b1 || PC !== 10'h020) begin
          n_fail++;
          $display("FAIL halt_pc: got halted=%b pc=%h, want halted=1 pc=020",
                   Halted, PC);
        end
      end
    end
  endtask

  task automatic test_underflow();
    stim_t q[$];
    exp_t  e, o;
    q.push_back(s_rst());
    q.push_back(s_jr(10'h009));
    q.push_back(s_ret());
    q.push_back(s_jal(10'h070));
    q.push_back(s_rst());
    foreach (q[i]) begin
      apply(q[i]);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL underflow step %0d: got %s, want %s", i, fmt(o), fmt(e));
      end
      if (i == 2) begin
        n_run++;
        if (Stack_Underflow !== 1'b1 || Halted !== 1'b1 || PC !== 10'h009) begin
          n_fail++;
          $display("FAIL underflow_flag: got %s, want pc=009 halted=1 udf=1",
                   fmt(o));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    stim_t bad;
    stim_t jb;
    exp_t  e, o;
    bad = s_ret();
    bad.jump = 1'b1;
    jb = s_jr(10'h0C0);
    jb.br = 1'b1; jb.taken = 1'b1; jb.btg = 10'h0D0;
    q.push_back(s_rst());
    q.push_back(s_jal(10'h010));
    q.push_back(s_ret());
    q.push_back(s_jal(10'h030));
    q.push_back(s_jal(10'h031));
    q.push_back(s_stall(s_jal(10'h200)));
    q.push_back(s_stall(s_ret()));
    q.push_back(bad);
    q.push_back(s_ret());
    q.push_back(jb);
    q.push_back(s_br(1'b1, 10'h3F0));
    q.push_back(bad);
    foreach (q[i]) begin
      apply(q[i]);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_jal_ret();
    test_overflow();
    test_branch_halt();
    test_underflow();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
